uart_cmd_assembler: RTL and testbench
=====================================

Name: uart_cmd_assembler

Overview:
Consumes the byte stream from the UART receiver (one-cycle data-valid strobe plus byte) and assembles fixed-format command frames for the coprocessor core. Each frame is sync, opcode, operand A, operand B, checksum. A frame that passes checksum is presented on a one-deep registered valid/ready output. Framing faults (bad checksum, inter-byte timeout, output overrun) are flagged with one-cycle error pulses.

Parameters:
OPERAND_BYTES, 4, bytes per operand (1..4); operand output width is 8*OPERAND_BYTES.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, 1740, maximum idle clocks between bytes inside a frame (20 bit times at 87 clks/bit); must be less than 65536.

Ports:
i_Clock  in  1  system clock.
i_Reset  in  1  synchronous, active-high reset.
i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte is valid.
i_Rx_Byte  in  8  received byte.
o_Cmd_Valid  out  1  command frame held on outputs.
i_Cmd_Ready  in  1  consumer accepts the command when high together with o_Cmd_Valid.
o_Cmd_Opcode  out  8  opcode.
o_Cmd_Op_A  out  8*OPERAND_BYTES  operand A.
o_Cmd_Op_B  out  8*OPERAND_BYTES  operand B.
o_Chk_Err  out  1  one-cycle pulse: checksum mismatch; frame dropped.
o_Timeout_Err  out  1  one-cycle pulse: inter-byte timeout; frame aborted.
o_Overrun_Err  out  1  one-cycle pulse: good frame completed while the output is still full; new frame dropped.

Behaviour:
- Reset: state S_SYNC; all outputs 0; byte index, timeout counter and running checksum cleared. Reset mid-frame discards the partial frame and any held command.
- Frame layout: SYNC_BYTE, OPCODE, A bytes (LSB first), B bytes (LSB first), CHK. CHK = XOR of OPCODE and all operand bytes. SYNC is not included in CHK.
- States and transitions, each advancing only on i_Rx_DV:
  - S_SYNC: a byte equal to SYNC_BYTE moves to S_OPCODE. Any other byte is ignored silently, with no error.
  - S_OPCODE: store the opcode, checksum = byte, move to S_OPA.
  - S_OPA: store byte[index], checksum ^= byte. After OPERAND_BYTES bytes, clear the index and move to S_OPB.
  - S_OPB: same handling as S_OPA; afterwards move to S_CHECK.
  - S_CHECK: compare the byte with the checksum, then always return to S_SYNC.
- Inside a frame, a SYNC_BYTE value is treated as data. There is no resynchronisation.
- Checksum outcomes in S_CHECK:
  - Match, and the output is empty or draining this cycle (o_Cmd_Valid && i_Cmd_Ready): load the output registers. o_Cmd_Valid goes high the cycle after the CHK strobe (latency 1 clk).
  - Match, but the output is full and not draining: o_Overrun_Err pulses the next cycle. The held command is unchanged.
  - Mismatch: o_Chk_Err pulses the next cycle. The output is untouched.
- Output handshake:
  - o_Cmd_Valid stays high and the output data stays stable until a cycle with i_Cmd_Ready high.
  - o_Cmd_Valid clears after that accept unless a new frame loads in the same cycle; in that case it stays high with the new data.
  - i_Cmd_Ready while o_Cmd_Valid is low has no effect.
- Assembly continues while a command is held, so the output acts as a one-deep buffer.
- Timeout counter (16 bits):
  - Active only in states other than S_SYNC; cleared on every i_Rx_DV and on entry to S_SYNC.
  - When it reaches TIMEOUT_CLKS-1 with no strobe: go to S_SYNC and pulse o_Timeout_Err the next cycle.
  - If a strobe coincides with the terminal count, the byte is processed and no timeout is raised.
- Error pulses are registered, last exactly one clock, and are mutually exclusive per frame.
- Back-to-back strobes on consecutive cycles must be handled. Every state accepts a byte in any cycle.

Test Plan:
- Nominal frame, i_Cmd_Ready tied high: A5 01 78 56 34 12 02 00 00 00 0B -> o_Cmd_Valid high 1 clk after the 0B strobe; opcode 01, Op_A 32'h12345678, Op_B 32'h00000002; no error pulses.
- Bad checksum: same frame with CHK 0C -> o_Chk_Err single pulse, o_Cmd_Valid stays 0, next valid frame accepted normally.
- Garbage then frame: 00 FF 3C, then the nominal frame -> garbage ignored silently, command as in the nominal case.
- Timeout: A5 01 78, then no strobe for 1740 clks -> o_Timeout_Err pulse exactly at the count; subsequent nominal frame decoded correctly.
- Backpressure and overrun:
  - i_Cmd_Ready=0, send two good frames -> first held stable, o_Overrun_Err pulses after the second CHK.
  - Assert i_Cmd_Ready in the same cycle as the second CHK strobe -> no overrun; second frame replaces the first and o_Cmd_Valid stays high.
- Reset mid-frame: i_Reset high after A5 01 78 -> all outputs 0, state S_SYNC; full nominal frame afterwards decodes correctly.

Source files
------------

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler
//   Assembles fixed-format command frames from a UART receiver byte stream.
//   Frame: SYNC_BYTE, OPCODE, A bytes (LSB first), B bytes (LSB first), CHK.
//   CHK is the XOR of OPCODE and all operand bytes.
//   A good frame is presented on a one-deep registered valid/ready output.
//   Faults are reported as one-cycle registered error pulses.
//
// Ports:
//   i_Clock        system clock
//   i_Reset        synchronous, active-high reset
//   i_Rx_DV        one-cycle strobe qualifying i_Rx_Byte
//   i_Rx_Byte      received byte
//   o_Cmd_Valid    command held on the outputs
//   i_Cmd_Ready    consumer accepts the command when high with o_Cmd_Valid
//   o_Cmd_Opcode   opcode
//   o_Cmd_Op_A     operand A (8*OPERAND_BYTES bits)
//   o_Cmd_Op_B     operand B (8*OPERAND_BYTES bits)
//   o_Chk_Err      pulse: checksum mismatch, frame dropped
//   o_Timeout_Err  pulse: inter-byte timeout, frame aborted
//   o_Overrun_Err  pulse: good frame finished while output full, frame dropped
module uart_cmd_assembler #(
    parameter int         OPERAND_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CLKS  = 1740
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Rx_DV,
    input  logic [7:0]                 i_Rx_Byte,
    output logic                       o_Cmd_Valid,
    input  logic                       i_Cmd_Ready,
    output logic [7:0]                 o_Cmd_Opcode,
    output logic [8*OPERAND_BYTES-1:0] o_Cmd_Op_A,
    output logic [8*OPERAND_BYTES-1:0] o_Cmd_Op_B,
    output logic                       o_Chk_Err,
    output logic                       o_Timeout_Err,
    output logic                       o_Overrun_Err
);

    localparam int          W        = 8 * OPERAND_BYTES;
    localparam logic [2:0]  LAST_IDX = 3'(OPERAND_BYTES - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_OPCODE,
        S_OPA,
        S_OPB,
        S_CHECK
    } state_t;

    state_t         state;
    logic [2:0]     idx;
    logic [7:0]     chk;
    logic [7:0]     opcode;
    logic [W-1:0]   a_buf;
    logic [W-1:0]   b_buf;
    logic [15:0]    tmo_cnt;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state         <= S_SYNC;
            idx           <= '0;
            chk           <= '0;
            opcode        <= '0;
            a_buf         <= '0;
            b_buf         <= '0;
            tmo_cnt       <= '0;
            o_Cmd_Valid   <= 1'b0;
            o_Cmd_Opcode  <= '0;
            o_Cmd_Op_A    <= '0;
            o_Cmd_Op_B    <= '0;
            o_Chk_Err     <= 1'b0;
            o_Timeout_Err <= 1'b0;
            o_Overrun_Err <= 1'b0;
        end else begin
            o_Chk_Err     <= 1'b0;
            o_Timeout_Err <= 1'b0;
            o_Overrun_Err <= 1'b0;

            // Accept retires the held command; a load below in the same
            // cycle overrides this and keeps valid high with new data.
            if (o_Cmd_Valid && i_Cmd_Ready)
                o_Cmd_Valid <= 1'b0;

            if (i_Rx_DV) begin
                // A strobe always wins over the terminal count.
                tmo_cnt <= '0;
                case (state)
                    S_SYNC: begin
                        if (i_Rx_Byte == SYNC_BYTE)
                            state <= S_OPCODE;
                    end
                    S_OPCODE: begin
                        opcode <= i_Rx_Byte;
                        chk    <= i_Rx_Byte;
                        idx    <= '0;
                        state  <= S_OPA;
                    end
                    S_OPA: begin
                        for (int i = 0; i < OPERAND_BYTES; i++)
                            if (idx == 3'(i)) a_buf[8*i +: 8] <= i_Rx_Byte;
                        chk <= chk ^ i_Rx_Byte;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_OPB;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    S_OPB: begin
                        for (int i = 0; i < OPERAND_BYTES; i++)
                            if (idx == 3'(i)) b_buf[8*i +: 8] <= i_Rx_Byte;
                        chk <= chk ^ i_Rx_Byte;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_CHECK;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    S_CHECK: begin
                        state <= S_SYNC;
                        if (i_Rx_Byte != chk) begin
                            o_Chk_Err <= 1'b1;
                        end else if (!o_Cmd_Valid || i_Cmd_Ready) begin
                            o_Cmd_Valid  <= 1'b1;
                            o_Cmd_Opcode <= opcode;
                            o_Cmd_Op_A   <= a_buf;
                            o_Cmd_Op_B   <= b_buf;
                        end else begin
                            o_Overrun_Err <= 1'b1;
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end else if (state != S_SYNC) begin
                // Idle inside a frame: abort once TIMEOUT_CLKS clocks pass.
                if (tmo_cnt == TMO_LAST) begin
                    state         <= S_SYNC;
                    tmo_cnt       <= '0;
                    o_Timeout_Err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler
//   Directed scenarios from the frame rules plus a randomized run checked
//   against a frame-level reference model built from byte lists.
module tb_uart_cmd_assembler;

    localparam int OB   = 4;
    localparam int TMO  = 1740;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_op_a;
    logic [31:0] cmd_op_b;
    logic        chk_err;
    logic        tmo_err;
    logic        ovr_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_chk_p  = 0;
    int n_tmo_p  = 0;
    int n_ovr_p  = 0;

    logic [7:0] frm[$];
    logic [7:0] nom [11] = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'h02, 8'h00, 8'h00, 8'h00, 8'h0B};

    uart_cmd_assembler #(.OPERAND_BYTES(OB), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Cmd_Valid   (cmd_valid),
        .i_Cmd_Ready   (cmd_ready),
        .o_Cmd_Opcode  (cmd_opcode),
        .o_Cmd_Op_A    (cmd_op_a),
        .o_Cmd_Op_B    (cmd_op_b),
        .o_Chk_Err     (chk_err),
        .o_Timeout_Err (tmo_err),
        .o_Overrun_Err (ovr_err)
    );

    always #5 clk = ~clk;

    // Count every error-pulse cycle so duplicated or stray pulses show up.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_err) n_chk_p++;
            if (tmo_err) n_tmo_p++;
            if (ovr_err) n_ovr_p++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_nominal();
        for (int i = 0; i < 11; i++) send(nom[i]);
    endtask

    // Build a frame into frm; corrupt != 0 spoils the checksum byte.
    task automatic make_frame(input logic [7:0] opc, input logic [31:0] a,
                              input logic [31:0] b, input logic [7:0] corrupt);
        logic [7:0] c;
        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(opc);
        c = opc;
        for (int i = 0; i < OB; i++) begin frm.push_back(a[8*i +: 8]); c ^= a[8*i +: 8]; end
        for (int i = 0; i < OB; i++) begin frm.push_back(b[8*i +: 8]); c ^= b[8*i +: 8]; end
        frm.push_back(c ^ corrupt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rx_dv = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b0;
        do_reset();
        n_checks++;
        if ({cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b, chk_err, tmo_err, ovr_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b op=%h a=%h b=%h errs=%b%b%b, want all zero",
                     cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b, chk_err, tmo_err, ovr_err);
        end
    endtask

    task automatic test_nominal();
        int c0, t0, o0;
        c0 = n_chk_p; t0 = n_tmo_p; o0 = n_ovr_p;
        cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(nom[i]);
        n_checks++;
        if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL nominal_early_valid: got %b want 0", cmd_valid);
        end
        send(nom[10]);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_op_a !== 32'h12345678 || cmd_op_b !== 32'h2) begin
            n_fail++;
            $display("FAIL nominal_cmd: got v=%b op=%h a=%h b=%h want v=1 op=01 a=12345678 b=00000002",
                     cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        tick();
        n_checks++;
        if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL nominal_accept: valid got %b want 0", cmd_valid);
        end
        n_checks++;
        if (n_chk_p != c0 || n_tmo_p != t0 || n_ovr_p != o0) begin
            n_fail++; $display("FAIL nominal_no_err: pulses chk=%0d tmo=%0d ovr=%0d want 0",
                               n_chk_p - c0, n_tmo_p - t0, n_ovr_p - o0);
        end
    endtask

    task automatic test_bad_chk();
        int c0;
        c0 = n_chk_p;
        cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(nom[i]);
        send(8'h0C);
        n_checks++;
        if (chk_err !== 1'b1 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL bad_chk_pulse: got err=%b v=%b want err=1 v=0", chk_err, cmd_valid);
        end
        tick();
        n_checks++;
        if (chk_err !== 1'b0 || n_chk_p != c0 + 1 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL bad_chk_single: err=%b pulses=%0d v=%b want 0,1,0",
                               chk_err, n_chk_p - c0, cmd_valid);
        end
        send_nominal();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_op_a !== 32'h12345678 || cmd_op_b !== 32'h2) begin
            n_fail++; $display("FAIL bad_chk_recover: got v=%b op=%h a=%h b=%h", cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        tick();
    endtask

    task automatic test_garbage();
        int c0, t0, o0;
        c0 = n_chk_p; t0 = n_tmo_p; o0 = n_ovr_p;
        cmd_ready = 1'b1;
        send(8'h00); send(8'hFF); send(8'h3C);
        tick(); tick();
        n_checks++;
        if (cmd_valid !== 1'b0 || n_chk_p != c0 || n_tmo_p != t0 || n_ovr_p != o0) begin
            n_fail++; $display("FAIL garbage_silent: v=%b pulses chk=%0d tmo=%0d ovr=%0d want all 0",
                               cmd_valid, n_chk_p - c0, n_tmo_p - t0, n_ovr_p - o0);
        end
        send_nominal();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_op_a !== 32'h12345678 || cmd_op_b !== 32'h2) begin
            n_fail++; $display("FAIL garbage_then_frame: got v=%b op=%h a=%h b=%h", cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        tick();
    endtask

    task automatic test_timeout();
        int t0;
        t0 = n_tmo_p;
        cmd_ready = 1'b1;
        send(8'hA5); send(8'h01); send(8'h78);
        for (int i = 0; i < TMO - 1; i++) tick();
        n_checks++;
        if (tmo_err !== 1'b0 || n_tmo_p != t0) begin
            n_fail++; $display("FAIL timeout_early: err=%b pulses=%0d want 0 before count", tmo_err, n_tmo_p - t0);
        end
        tick();
        n_checks++;
        if (tmo_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_at_count: err got %b want 1", tmo_err);
        end
        tick();
        n_checks++;
        if (tmo_err !== 1'b0 || n_tmo_p != t0 + 1 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_single: err=%b pulses=%0d v=%b want 0,1,0", tmo_err, n_tmo_p - t0, cmd_valid);
        end
        send_nominal();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_op_a !== 32'h12345678 || cmd_op_b !== 32'h2) begin
            n_fail++; $display("FAIL timeout_recover: got v=%b op=%h a=%h b=%h", cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        tick();
    endtask

    task automatic test_overrun();
        int o0;
        o0 = n_ovr_p;
        cmd_ready = 1'b0;
        make_frame(8'h11, 32'hCAFE_0001, 32'h0000_BEEF, 8'h00);
        foreach (frm[i]) send(frm[i]);
        make_frame(8'h22, 32'h1111_2222, 32'h3333_4444, 8'h00);
        foreach (frm[i]) send(frm[i]);
        n_checks++;
        if (ovr_err !== 1'b1 || cmd_valid !== 1'b1 || cmd_opcode !== 8'h11 ||
            cmd_op_a !== 32'hCAFE_0001 || cmd_op_b !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL overrun_pulse: err=%b v=%b op=%h a=%h b=%h want 1,1,11,cafe0001,0000beef",
                               ovr_err, cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (ovr_err !== 1'b0 || n_ovr_p != o0 + 1 || cmd_valid !== 1'b1 || cmd_opcode !== 8'h11) begin
            n_fail++; $display("FAIL overrun_hold: err=%b pulses=%0d v=%b op=%h want 0,1,1,11",
                               ovr_err, n_ovr_p - o0, cmd_valid, cmd_opcode);
        end
        // Ready coincides with the CHK strobe: replace rather than overrun.
        make_frame(8'h33, 32'h0BAD_F00D, 32'h5555_AAAA, 8'h00);
        for (int i = 0; i < frm.size() - 1; i++) send(frm[i]);
        cmd_ready = 1'b1;
        send(frm[frm.size() - 1]);
        cmd_ready = 1'b0;
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h33 || cmd_op_a !== 32'h0BAD_F00D ||
            cmd_op_b !== 32'h5555_AAAA || n_ovr_p != o0 + 1) begin
            n_fail++; $display("FAIL drain_replace: v=%b op=%h a=%h b=%h ovr_pulses=%0d want 1,33,0badf00d,5555aaaa,1",
                               cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b, n_ovr_p - o0);
        end
        cmd_ready = 1'b1;
        tick();
        n_checks++;
        if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_accept: valid got %b want 0", cmd_valid);
        end
    endtask

    task automatic test_reset_mid();
        cmd_ready = 1'b0;
        send_nominal();
        send(8'hA5); send(8'h01); send(8'h78);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b, chk_err, tmo_err, ovr_err} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: v=%b op=%h a=%h b=%h, want all zero",
                               cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        cmd_ready = 1'b1;
        send_nominal();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_op_a !== 32'h12345678 || cmd_op_b !== 32'h2) begin
            n_fail++; $display("FAIL reset_mid_recover: got v=%b op=%h a=%h b=%h", cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cmd_ready = 1'b1;
        make_frame(8'h44, 32'h0102_0304, 32'hA5A5_A5A5, 8'h00);
        foreach (frm[i]) send(frm[i]);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h44 || cmd_op_a !== 32'h0102_0304 || cmd_op_b !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL b2b_first: got v=%b op=%h a=%h b=%h", cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        make_frame(8'hA5, 32'hFFFF_FFFF, 32'h8000_0001, 8'h00);
        foreach (frm[i]) send(frm[i]);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'hA5 || cmd_op_a !== 32'hFFFF_FFFF || cmd_op_b !== 32'h8000_0001) begin
            n_fail++; $display("FAIL b2b_second: got v=%b op=%h a=%h b=%h", cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b);
        end
        tick();
    endtask

    // Randomized frames, garbage and gaps with random ready. The model tracks
    // the one-deep output buffer at frame granularity.
    task automatic test_random();
        bit          dv_q[$];
        logic [7:0]  b_q[$];
        int          k_q[$];
        logic [7:0]  eo_q[$];
        logic [31:0] ea_q[$], eb_q[$];
        logic [7:0]  opc, corrupt, g;
        logic [31:0] a, b;
        bit          mv, rdy, ld, ovr;
        logic [7:0]  mo;
        logic [31:0] ma, mb;
        int          nerr;
        do_reset();
        for (int f = 0; f < 40; f++) begin
            opc = 8'($urandom); a = $urandom; b = $urandom;
            corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int gi = 0; gi < int'($urandom_range(0, 2)); gi++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                dv_q.push_back(1); b_q.push_back(g); k_q.push_back(0);
                eo_q.push_back(0); ea_q.push_back(0); eb_q.push_back(0);
            end
            make_frame(opc, a, b, corrupt);
            foreach (frm[i]) begin
                for (int gp = 0; gp < int'($urandom_range(0, 3)); gp++) begin
                    dv_q.push_back(0); b_q.push_back(0); k_q.push_back(0);
                    eo_q.push_back(0); ea_q.push_back(0); eb_q.push_back(0);
                end
                dv_q.push_back(1); b_q.push_back(frm[i]);
                k_q.push_back(i == frm.size() - 1 ? (corrupt == 0 ? 1 : 2) : 0);
                eo_q.push_back(opc); ea_q.push_back(a); eb_q.push_back(b);
            end
        end
        mv = 0; mo = 0; ma = 0; mb = 0; nerr = 0;
        foreach (dv_q[c]) begin
            rdy = 1'($urandom);
            ld  = (k_q[c] == 1) && (!mv || rdy);
            ovr = (k_q[c] == 1) && mv && !rdy;
            if (ld) begin mv = 1; mo = eo_q[c]; ma = ea_q[c]; mb = eb_q[c]; end
            else if (mv && rdy) mv = 0;
            cmd_ready = rdy;
            rx_dv     = dv_q[c];
            rx_byte   = b_q[c];
            tick();
            rx_dv = 1'b0;
            n_checks++;
            if (cmd_valid !== mv || (mv && (cmd_opcode !== mo || cmd_op_a !== ma || cmd_op_b !== mb)) ||
                chk_err !== (k_q[c] == 2) || ovr_err !== ovr || tmo_err !== 1'b0) begin
                n_fail++;
                if (nerr < 10)
                    $display("FAIL random_cycle%0d: v=%b op=%h a=%h b=%h ce=%b oe=%b te=%b want v=%b op=%h a=%h b=%h ce=%b oe=%b te=0",
                             c, cmd_valid, cmd_opcode, cmd_op_a, cmd_op_b, chk_err, ovr_err, tmo_err,
                             mv, mo, ma, mb, k_q[c] == 2, ovr);
                nerr++;
            end
        end
        cmd_ready = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b0;
        test_reset();
        test_nominal();
        test_bad_chk();
        test_garbage();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
